// File: rtl/comparator_ctrl_pkg.sv
// Shared definitions for the comparator-sharing controller.
//   - state_e   : controller FSM states
//   - RES_*     : bit positions of {greater, equal, less} inside a result triple
//   - cnt_width : width of the settle counter for a given settle window
package comparator_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    ENABLE  = 3'd2,
    CAPTURE = 3'd3,
    GATE    = 3'd4
  } state_e;

  localparam int RES_LT = 0;
  localparam int RES_EQ = 1;
  localparam int RES_GT = 2;

  // Counter has to hold 0..settle-1; sized for settle+1 so settle=1 still gets one bit.
  function automatic int cnt_width(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/comparator_share_ctrl_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset (pointer -> 0)
//   i_req        : request vector
//   i_arb        : arbitrate strobe; o_grant is zero when low
//   i_upd        : pointer update strobe
//   i_upd_idx    : index just served; pointer moves to the slot after it
//   o_grant      : one-hot grant (combinational)
//   o_idx        : encoded index of the winning requester (combinational)
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_arb,
  input  logic             i_upd,
  input  logic [IW-1:0]    i_upd_idx,
  output logic [N_REQ-1:0] o_grant,
  output logic [IW-1:0]    o_idx
);

  logic [IW-1:0]    r_ptr;
  logic [N_REQ-1:0] w_grant;
  logic [IW-1:0]    w_idx;
  logic             w_found;
  int               w_cand;

  // Search upward from the pointer, wrapping past N_REQ-1 back to 0.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = int'(r_ptr) + k;
      if (w_cand >= N_REQ) w_cand = w_cand - N_REQ;
      if (!w_found && i_req[IW'(w_cand)]) begin
        w_found              = 1'b1;
        w_grant[IW'(w_cand)] = 1'b1;
        w_idx                = IW'(w_cand);
      end
    end
  end

  assign o_grant = i_arb ? w_grant : '0;
  assign o_idx   = w_idx;

  // The served requester drops to lowest priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (i_upd) begin
      r_ptr <= (i_upd_idx == IW'(N_REQ - 1)) ? '0 : i_upd_idx + 1'b1;
    end
  end

endmodule

// File: rtl/comparator_share_ctrl.sv
// Time-shares one power-gated comparator among N_REQ requesters.
// Sequence per operation: IDLE -> LOAD -> ENABLE (SETTLE cycles) -> CAPTURE -> GATE.
// Ports:
//   clk, reset                   : clock, asynchronous active-low reset
//   req, a_bus, b_bus            : level requests and packed operands (slot i at [i*(n+1)+:n+1])
//   grant, done, busy            : owner (one-hot), result-valid pulse, not-idle flag
//   less_than/equal_to/greater_than, cmp_err : held result, non-one-hot result pulse
//   cmp_enable, cmp_reset, cmp_a, cmp_b       : comparator control and operands
//   cmp_less, cmp_equal, cmp_greater          : comparator outputs
// All outputs come straight from registers.
module comparator_share_ctrl
  import comparator_ctrl_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int n      = 3,
  parameter int SETTLE = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*(n+1)-1:0] a_bus,
  input  logic [N_REQ*(n+1)-1:0] b_bus,
  output logic [N_REQ-1:0]       grant,
  output logic                   done,
  output logic                   less_than,
  output logic                   equal_to,
  output logic                   greater_than,
  output logic                   cmp_err,
  output logic                   busy,
  output logic                   cmp_enable,
  output logic                   cmp_reset,
  output logic [n:0]             cmp_a,
  output logic [n:0]             cmp_b,
  input  logic                   cmp_less,
  input  logic                   cmp_equal,
  input  logic                   cmp_greater
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = cnt_width(SETTLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  generate
    if (SETTLE < 1) begin : g_bad_settle
      $error("comparator_share_ctrl: SETTLE must be at least 1");
    end
  endgenerate

  state_e           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [IW-1:0]    r_idx;
  logic [N_REQ-1:0] r_grant;
  logic             r_done, r_err, r_busy, r_en, r_rst;
  logic             r_lt, r_eq, r_gt;
  logic [n:0]       r_cmp_a, r_cmp_b;

  logic [N_REQ-1:0] w_arb_grant;
  logic [IW-1:0]    w_arb_idx;
  logic [n:0]       w_a_sel, w_b_sel;
  logic [2:0]       w_triple;
  logic             w_bad;
  logic             w_start, w_capture;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_req     (req),
    .i_arb     (r_state == IDLE),
    .i_upd     (r_state == CAPTURE),
    .i_upd_idx (r_idx),
    .o_grant   (w_arb_grant),
    .o_idx     (w_arb_idx)
  );

  // Operand slice of the arbitration winner.
  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_arb_idx == IW'(i)) begin
        w_a_sel = a_bus[i*(n+1) +: n+1];
        w_b_sel = b_bus[i*(n+1) +: n+1];
      end
    end
  end

  always_comb begin
    w_triple         = '0;
    w_triple[RES_LT] = cmp_less;
    w_triple[RES_EQ] = cmp_equal;
    w_triple[RES_GT] = cmp_greater;
    w_bad = !((w_triple == 3'b001) || (w_triple == 3'b010) || (w_triple == 3'b100));
  end

  // Next state; the settle counter restarts at 0 on entry to ENABLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      IDLE:    if (|req) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = ENABLE;
      ENABLE: begin
        if (r_cnt == CNT_LAST) w_state_nxt = CAPTURE;
        else                   w_cnt_nxt   = r_cnt + 1'b1;
      end
      CAPTURE: w_state_nxt = GATE;
      GATE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_start   = (r_state == IDLE) && (w_state_nxt == LOAD);
  assign w_capture = (r_state == ENABLE) && (w_state_nxt == CAPTURE);

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_grant <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_en    <= 1'b0;
      r_rst   <= 1'b0;
      r_lt    <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_cmp_a <= '0;
      r_cmp_b <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_capture;
      r_en    <= (w_state_nxt == ENABLE) || (w_state_nxt == CAPTURE);
      r_rst   <= (w_state_nxt == GATE);
      r_err   <= w_capture && w_bad;

      // Operands stay put after LOAD so the comparator sees stable inputs.
      if (w_start) begin
        r_grant <= w_arb_grant;
        r_idx   <= w_arb_idx;
        r_cmp_a <= w_a_sel;
        r_cmp_b <= w_b_sel;
      end else if (w_state_nxt == GATE || w_state_nxt == IDLE) begin
        r_grant <= '0;
      end

      // A malformed triple is still forwarded; cmp_err flags it.
      if (w_capture) begin
        r_lt <= cmp_less;
        r_eq <= cmp_equal;
        r_gt <= cmp_greater;
      end
    end
  end

  assign grant        = r_grant;
  assign done         = r_done;
  assign cmp_err      = r_err;
  assign busy         = r_busy;
  assign cmp_enable   = r_en;
  assign cmp_reset    = r_rst;
  assign cmp_a        = r_cmp_a;
  assign cmp_b        = r_cmp_b;
  assign less_than    = r_lt;
  assign equal_to     = r_eq;
  assign greater_than = r_gt;

endmodule

// File: tb/tb_comparator_share_ctrl.sv
// Directed bench for comparator_share_ctrl (N_REQ=4, n=3, SETTLE=4) with a
// behavioural comparator that can be forced to produce a malformed result.
module tb_comparator_share_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] a_bus = '0;
  logic [15:0] b_bus = '0;
  logic [3:0]  grant;
  logic        done, less_than, equal_to, greater_than, cmp_err, busy;
  logic        cmp_enable, cmp_reset;
  logic [3:0]  cmp_a, cmp_b;
  logic        cmp_less, cmp_equal, cmp_greater;
  logic        fault = 1'b0;

  int checks = 0;
  int failures = 0;

  // Observation results
  int n_grant, n_en, n_done, n_rst, n_err, rst_at;
  int done_k [0:3];
  logic [3:0] gnt_d [0:3];
  logic lt_d, eq_d, gt_d, err_d, busy_end;

  always #5 clk = ~clk;

  // Comparator model: outputs only meaningful while enabled.
  assign cmp_less    = cmp_enable & (fault | (cmp_a < cmp_b));
  assign cmp_greater = cmp_enable & (fault | (cmp_a > cmp_b));
  assign cmp_equal   = cmp_enable & ~fault & (cmp_a == cmp_b);

  comparator_share_ctrl #(.N_REQ(4), .n(3), .SETTLE(4)) dut (
    .clk(clk), .reset(reset), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .grant(grant), .done(done), .less_than(less_than), .equal_to(equal_to),
    .greater_than(greater_than), .cmp_err(cmp_err), .busy(busy),
    .cmp_enable(cmp_enable), .cmp_reset(cmp_reset), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_less(cmp_less), .cmp_equal(cmp_equal), .cmp_greater(cmp_greater)
  );

  task automatic set_ops(input int idx, input logic [3:0] a, input logic [3:0] b);
    a_bus[idx*4 +: 4] = a;
    b_bus[idx*4 +: 4] = b;
  endtask

  // Records what happens over ncyc edges; k=0 is the first edge after the call.
  task automatic observe(input int ncyc, input int drop_after, input bit drop_first);
    n_grant = 0; n_en = 0; n_done = 0; n_rst = 0; n_err = 0; rst_at = -1;
    for (int j = 0; j < 4; j++) begin done_k[j] = -1; gnt_d[j] = '0; end
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      if (drop_first && k == 0) req = '0;
      if (grant != 4'b0) n_grant++;
      if (cmp_enable) n_en++;
      if (cmp_err) n_err++;
      if (cmp_reset) begin n_rst++; if (rst_at < 0) rst_at = k; end
      if (done) begin
        if (n_done < 4) begin done_k[n_done] = k; gnt_d[n_done] = grant; end
        n_done++;
        lt_d = less_than; eq_d = equal_to; gt_d = greater_than; err_d = cmp_err;
        if (drop_after > 0 && n_done == drop_after) req = '0;
      end
    end
    busy_end = busy;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({grant, done, cmp_err, busy, cmp_enable, cmp_reset} !== 9'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=0", {grant, done, cmp_err, busy, cmp_enable, cmp_reset});
    end
    checks++;
    if ({cmp_a, cmp_b, less_than, equal_to, greater_than} !== 11'b0) begin
      failures++;
      $display("FAIL reset_data got=%b want=0", {cmp_a, cmp_b, less_than, equal_to, greater_than});
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    set_ops(0, 4'd5, 4'd3);
    req = 4'b0001;
    observe(10, 0, 1'b1);
    checks++;
    if (gnt_d[0] !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b want=0001", gnt_d[0]); end
    checks++;
    if (n_grant != 6) begin failures++; $display("FAIL single_grant_len got=%0d want=6", n_grant); end
    checks++;
    if (n_en != 5) begin failures++; $display("FAIL single_enable_len got=%0d want=5", n_en); end
    checks++;
    if (done_k[0] != 5 || n_done != 1) begin
      failures++; $display("FAIL single_done_at got=%0d cnt=%0d want=5 cnt=1", done_k[0], n_done);
    end
    checks++;
    if ({lt_d, eq_d, gt_d, err_d} !== 4'b0010) begin
      failures++; $display("FAIL single_result got=%b want=0010", {lt_d, eq_d, gt_d, err_d});
    end
    checks++;
    if (rst_at != 6 || n_rst != 1) begin
      failures++; $display("FAIL single_cmp_reset got=%0d cnt=%0d want=6 cnt=1", rst_at, n_rst);
    end
    checks++;
    if (cmp_a !== 4'd5 || cmp_b !== 4'd3) begin
      failures++; $display("FAIL single_operands got=%0d,%0d want=5,3", cmp_a, cmp_b);
    end
  endtask

  task automatic test_equal();
    set_ops(2, 4'd9, 4'd9);
    req = 4'b0100;
    observe(9, 0, 1'b1);
    checks++;
    if (gnt_d[0] !== 4'b0100) begin failures++; $display("FAIL equal_grant got=%b want=0100", gnt_d[0]); end
    checks++;
    if (n_done != 1 || {lt_d, eq_d, gt_d, err_d} !== 4'b0100) begin
      failures++; $display("FAIL equal_result got=%b cnt=%0d want=0100 cnt=1", {lt_d, eq_d, gt_d, err_d}, n_done);
    end
  endtask

  task automatic test_contention();
    reset = 1'b0; #3; reset = 1'b1;
    @(posedge clk); #1;
    set_ops(1, 4'd1, 4'd2);
    set_ops(3, 4'd8, 4'd2);
    req = 4'b1010;
    observe(32, 3, 1'b0);
    checks++;
    if (n_done != 3) begin failures++; $display("FAIL rr_done_count got=%0d want=3", n_done); end
    checks++;
    if (gnt_d[0] !== 4'b0010 || gnt_d[1] !== 4'b1000 || gnt_d[2] !== 4'b0010) begin
      failures++; $display("FAIL rr_order got=%b,%b,%b want=0010,1000,0010", gnt_d[0], gnt_d[1], gnt_d[2]);
    end
    checks++;
    if (done_k[0] != 5 || done_k[1] != 13 || done_k[2] != 21) begin
      failures++; $display("FAIL rr_spacing got=%0d,%0d,%0d want=5,13,21", done_k[0], done_k[1], done_k[2]);
    end
    checks++;
    if (busy_end !== 1'b0) begin failures++; $display("FAIL rr_idle_after got=%b want=0", busy_end); end
  endtask

  task automatic test_early_drop();
    set_ops(0, 4'd2, 4'd7);
    req = 4'b0001;
    observe(20, 0, 1'b1);
    checks++;
    if (n_done != 1 || gnt_d[0] !== 4'b0001) begin
      failures++; $display("FAIL drop_done got=%0d grant=%b want=1 grant=0001", n_done, gnt_d[0]);
    end
    checks++;
    if ({lt_d, eq_d, gt_d} !== 3'b100) begin
      failures++; $display("FAIL drop_result got=%b want=100", {lt_d, eq_d, gt_d});
    end
  endtask

  task automatic test_reset_mid();
    set_ops(2, 4'd12, 4'd3);
    req = 4'b0100;
    repeat (3) begin @(posedge clk); #1; end   // LOAD, ENABLE#1, ENABLE#2
    checks++;
    if (cmp_enable !== 1'b1) begin failures++; $display("FAIL mid_pre_enable got=%b want=1", cmp_enable); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (cmp_enable !== 1'b0 || grant !== 4'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL mid_async got=%b/%b/%b want=0/0000/0", cmp_enable, grant, busy);
    end
    #1 reset = 1'b1;
    req = '0;
    observe(10, 0, 1'b0);
    checks++;
    if (n_done != 0 || n_en != 0) begin
      failures++; $display("FAIL mid_no_done got=%0d en=%0d want=0 en=0", n_done, n_en);
    end
    req = 4'b0100;
    observe(9, 0, 1'b1);
    checks++;
    if (n_done != 1 || gnt_d[0] !== 4'b0100 || {lt_d, eq_d, gt_d} !== 3'b001) begin
      failures++; $display("FAIL mid_restart got=%0d grant=%b res=%b want=1 grant=0100 res=001",
                           n_done, gnt_d[0], {lt_d, eq_d, gt_d});
    end
  endtask

  task automatic test_fault();
    fault = 1'b1;
    set_ops(0, 4'd1, 4'd6);
    req = 4'b0001;
    observe(9, 0, 1'b1);
    fault = 1'b0;
    checks++;
    if (n_done != 1 || err_d !== 1'b1 || n_err != 1) begin
      failures++; $display("FAIL fault_err got=%0d err=%b errcnt=%0d want=1 err=1 errcnt=1", n_done, err_d, n_err);
    end
    checks++;
    if ({lt_d, eq_d, gt_d} !== 3'b101) begin
      failures++; $display("FAIL fault_forward got=%b want=101", {lt_d, eq_d, gt_d});
    end
    set_ops(1, 4'd4, 4'd4);
    req = 4'b0010;
    observe(9, 0, 1'b1);
    checks++;
    if (n_done != 1 || n_err != 0 || {lt_d, eq_d, gt_d, err_d} !== 4'b0100) begin
      failures++; $display("FAIL fault_clean got=%b errcnt=%0d want=0100 errcnt=0", {lt_d, eq_d, gt_d, err_d}, n_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_equal();
    test_contention();
    test_early_drop();
    test_reset_mid();
    test_fault();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
